// File: rtl/scoreboard_disp_pkg.sv
// scoreboard_disp_pkg: active-high 7-segment glyphs and segment bit positions.
package scoreboard_disp_pkg;
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;
endpackage

// File: rtl/bcd_to_segs.sv
// bcd_to_segs: BCD digit to active-high segments; non-decimal codes show a dash.
module bcd_to_segs
   import scoreboard_disp_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] segs
);
   always_comb begin
      case (code)
         4'd0:    segs = SEG_0;
         4'd1:    segs = SEG_1;
         4'd2:    segs = SEG_2;
         4'd3:    segs = SEG_3;
         4'd4:    segs = SEG_4;
         4'd5:    segs = SEG_5;
         4'd6:    segs = SEG_6;
         4'd7:    segs = SEG_7;
         4'd8:    segs = SEG_8;
         4'd9:    segs = SEG_9;
         default: segs = SEG_DASH;
      endcase
   end
endmodule

// File: rtl/scoreboard_scan_7segs.sv
// scoreboard_scan_7segs: multiplexed BCD 7-segment driver with frame-aligned
// double-buffered updates, leading-zero blanking and global enable.
module scoreboard_scan_7segs
   import scoreboard_disp_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int LZB            = 1,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*N_DIGITS-1:0] bcd_in,
   input  logic                  load,
   input  logic                  en,
   output logic [6:0]            segs,
   output logic [N_DIGITS-1:0]   an,
   output logic                  pending
);
   localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
   logic [PW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [4*N_DIGITS-1:0]   shadow, active;
   logic                    tick, frame, nz, cur_blank;
   logic [3:0]              cur;
   logic [6:0]              dec;
   logic [N_DIGITS-1:0]     sel;
   assign tick  = cnt == PW'(SCAN_DIV - 1);
   assign frame = tick && idx == IW'(N_DIGITS - 1);
   // Walk from the top digit down so nz tells whether any digit at or above k is non-zero.
   always_comb begin
      cur = '0;
      cur_blank = 1'b0;
      nz = 1'b0;
      sel = '0;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         nz = nz | (active[4*k +: 4] != 4'd0);
         if (idx == IW'(k)) begin
            cur = active[4*k +: 4];
            cur_blank = LZB != 0 && k != 0 && !nz;
         end
         sel[k] = en && idx == IW'(k);
      end
   end
   bcd_to_segs u_dec (.code(cur), .segs(dec));
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         idx     <= '0;
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
         segs    <= {7{SEG_ACTIVE_LOW != 0}};
         an      <= {N_DIGITS{AN_ACTIVE_LOW != 0}};
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) idx <= idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1;
         if (load) shadow <= bcd_in;
         if (frame && pending) active <= shadow;
         pending <= load | (pending & ~frame);
         segs <= (en && !cur_blank ? dec : SEG_OFF) ^ {7{SEG_ACTIVE_LOW != 0}};
         an   <= sel ^ {N_DIGITS{AN_ACTIVE_LOW != 0}};
      end
   end
endmodule

// File: tb/tb_scoreboard_scan_7segs.sv
// tb_scoreboard_scan_7segs: directed checks of scanning, frame-aligned loads,
// blanking, mid-frame reset and the single-digit / no-LZB parameter corners.
module tb_scoreboard_scan_7segs;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] bcd = '0;
   logic        load = 1'b0, en = 1'b1;
   logic [6:0]  segs;
   logic [3:0]  an;
   logic        pending;
   logic [15:0] bcd0 = '0;
   logic        load0 = 1'b0, en0 = 1'b1;
   logic [6:0]  segs0;
   logic [3:0]  an0;
   logic        pend0;
   logic [3:0]  bcd1 = '0;
   logic        load1 = 1'b0, en1 = 1'b1;
   logic [6:0]  segs1;
   logic [0:0]  an1;
   logic        pend1;
   int          cyc, total, bad;

   scoreboard_scan_7segs #(.N_DIGITS(4), .SCAN_DIV(4), .LZB(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
      .clk(clk), .reset(reset), .bcd_in(bcd), .load(load), .en(en),
      .segs(segs), .an(an), .pending(pending));
   scoreboard_scan_7segs #(.N_DIGITS(4), .SCAN_DIV(1), .LZB(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut0 (
      .clk(clk), .reset(reset), .bcd_in(bcd0), .load(load0), .en(en0),
      .segs(segs0), .an(an0), .pending(pend0));
   scoreboard_scan_7segs #(.N_DIGITS(1), .SCAN_DIV(1), .LZB(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut1 (
      .clk(clk), .reset(reset), .bcd_in(bcd1), .load(load1), .en(en1),
      .segs(segs1), .an(an1), .pending(pend1));

   always #5 clk = ~clk;

   // cyc == n at the falling edge following the n-th rising edge after reset release
   always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;

   task automatic goto(input int n);
      int g = 0;
      while (cyc < n && g < 1000) begin
         @(negedge clk);
         g++;
      end
      if (cyc < n) begin
         total++;
         bad++;
         $display("FAIL goto: cycle %0d never reached (at %0d)", n, cyc);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      total += 6;
      if (segs !== 7'h7F) begin bad++; $display("FAIL reset_segs: got %h want 7f", segs); end
      if (an !== 4'hF) begin bad++; $display("FAIL reset_an: got %h want f", an); end
      if (pending !== 1'b0) begin bad++; $display("FAIL reset_pending: got %b want 0", pending); end
      if (segs0 !== 7'h7F || an0 !== 4'hF) begin bad++; $display("FAIL reset_dut0: got %h/%h want 7f/f", segs0, an0); end
      if (segs1 !== 7'h7F || an1 !== 1'b1) begin bad++; $display("FAIL reset_dut1: got %h/%h want 7f/1", segs1, an1); end
      if (pend0 !== 1'b0 || pend1 !== 1'b0) begin bad++; $display("FAIL reset_pend01: got %b%b want 00", pend0, pend1); end
      reset = 1'b0;
   endtask

   task automatic test_load;
      logic [3:0] ea [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
      logic [6:0] es [4] = '{7'h78, 7'h24, 7'h19, 7'h7F};
      goto(1);
      total++;
      if (an !== 4'hE || segs !== 7'h40 || pending !== 1'b0) begin
         bad++; $display("FAIL first_edge: got an=%h segs=%h pend=%b want e/40/0", an, segs, pending);
      end
      bcd = 16'h0427; load = 1'b1;
      goto(2);
      load = 1'b0;
      total++;
      if (pending !== 1'b1) begin bad++; $display("FAIL load_pending: got %b want 1", pending); end
      goto(15);
      total++;
      if (pending !== 1'b1) begin bad++; $display("FAIL pending_hold: got %b want 1", pending); end
      goto(16);
      total++;
      if (pending !== 1'b0) begin bad++; $display("FAIL pending_clear: got %b want 0", pending); end
      for (int d = 0; d < 4; d++) begin
         for (int e = 0; e < 4; e += 3) begin
            goto(17 + 4*d + e);
            total++;
            if (an !== ea[d] || segs !== es[d]) begin
               bad++; $display("FAIL scan_0427 d%0d: got an=%h segs=%h want %h/%h", d, an, segs, ea[d], es[d]);
            end
         end
      end
   endtask

   task automatic test_invalid;
      logic [3:0] ea [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
      logic [6:0] es [4] = '{7'h40, 7'h3F, 7'h7F, 7'h7F};
      goto(33);
      bcd = 16'h00A0; load = 1'b1;
      goto(34);
      load = 1'b0;
      for (int d = 0; d < 4; d++) begin
         goto(49 + 4*d);
         total++;
         if (an !== ea[d] || segs !== es[d]) begin
            bad++; $display("FAIL scan_00a0 d%0d: got an=%h segs=%h want %h/%h", d, an, segs, ea[d], es[d]);
         end
      end
   endtask

   task automatic test_back_to_back;
      goto(65);
      bcd = 16'h2222; load = 1'b1;
      goto(66);
      load = 1'b0;
      goto(79);
      bcd = 16'h1111; load = 1'b1;
      goto(80);
      load = 1'b0;
      total++;
      if (pending !== 1'b1) begin bad++; $display("FAIL simul_pending: got %b want 1", pending); end
      goto(81);
      total++;
      if (an !== 4'hE || segs !== 7'h24) begin bad++; $display("FAIL simul_old0: got %h/%h want e/24", an, segs); end
      goto(93);
      total++;
      if (an !== 4'h7 || segs !== 7'h24) begin bad++; $display("FAIL simul_old3: got %h/%h want 7/24", an, segs); end
      goto(96);
      total++;
      if (pending !== 1'b0) begin bad++; $display("FAIL simul_clear: got %b want 0", pending); end
      goto(97);
      total++;
      if (an !== 4'hE || segs !== 7'h79) begin bad++; $display("FAIL simul_new0: got %h/%h want e/79", an, segs); end
      goto(109);
      total++;
      if (an !== 4'h7 || segs !== 7'h79) begin bad++; $display("FAIL simul_new3: got %h/%h want 7/79", an, segs); end
   endtask

   task automatic test_blank;
      goto(114);
      en = 1'b0;
      goto(115);
      total++;
      if (an !== 4'hF || segs !== 7'h7F) begin bad++; $display("FAIL blank_on: got %h/%h want f/7f", an, segs); end
      goto(117);
      total++;
      if (an !== 4'hF || segs !== 7'h7F) begin bad++; $display("FAIL blank_hold: got %h/%h want f/7f", an, segs); end
      en = 1'b1;
      goto(118);
      total++;
      if (an !== 4'hD || segs !== 7'h79) begin bad++; $display("FAIL blank_restore: got %h/%h want d/79", an, segs); end
      goto(120);
      total++;
      if (an !== 4'hD) begin bad++; $display("FAIL blank_slot_end: got %h want d", an); end
      goto(121);
      total++;
      if (an !== 4'hB) begin bad++; $display("FAIL blank_next_slot: got %h want b", an); end
   endtask

   task automatic test_reset_mid;
      bcd = 16'h5555; load = 1'b1;
      goto(122);
      load = 1'b0;
      total++;
      if (pending !== 1'b1 || an !== 4'hB) begin bad++; $display("FAIL mid_setup: got pend=%b an=%h want 1/b", pending, an); end
      #2 reset = 1'b1;
      #1;
      total++;
      if (an !== 4'hF || segs !== 7'h7F || pending !== 1'b0) begin
         bad++; $display("FAIL mid_async: got an=%h segs=%h pend=%b want f/7f/0", an, segs, pending);
      end
      @(negedge clk);
      reset = 1'b0;
      goto(1);
      total++;
      if (an !== 4'hE || segs !== 7'h40 || pending !== 1'b0) begin
         bad++; $display("FAIL mid_release: got an=%h segs=%h pend=%b want e/40/0", an, segs, pending);
      end
   endtask

   task automatic test_edge_params;
      logic [3:0] ea [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
      for (int n = 1; n <= 5; n++) begin
         goto(n);
         if (n <= 4) begin
            total++;
            if (an0 !== ea[n-1] || segs0 !== 7'h40) begin
               bad++; $display("FAIL nolzb n%0d: got an=%h segs=%h want %h/40", n, an0, segs0, ea[n-1]);
            end
         end
         total++;
         if (an1 !== 1'b0) begin bad++; $display("FAIL single_an n%0d: got %b want 0", n, an1); end
         if (n == 2) begin bcd1 = 4'h8; load1 = 1'b1; end
         if (n == 3) begin
            load1 = 1'b0;
            total++;
            if (pend1 !== 1'b1) begin bad++; $display("FAIL single_pending: got %b want 1", pend1); end
         end
         if (n == 4) begin
            total++;
            if (pend1 !== 1'b0 || segs1 !== 7'h40) begin bad++; $display("FAIL single_apply: got %b/%h want 0/40", pend1, segs1); end
         end
         if (n == 5) begin
            total++;
            if (segs1 !== 7'h00) begin bad++; $display("FAIL single_show: got %h want 00", segs1); end
         end
      end
   endtask

   task automatic test_discard;
      goto(17);
      total++;
      if (an !== 4'hE || segs !== 7'h40 || pending !== 1'b0) begin
         bad++; $display("FAIL discard: got an=%h segs=%h pend=%b want e/40/0", an, segs, pending);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset;
      test_load;
      test_invalid;
      test_back_to_back;
      test_blank;
      test_reset_mid;
      test_edge_params;
      test_discard;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
